// File: rtl/bcd_countdown60.sv
// Minutes:seconds BCD countdown timer using packed {tens, units} bytes.
// Loads a saturated start value, decrements once per enabled tick and pulses done at expiry.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | stopped; holds the loaded value or 00:00
// ST_RUN   | counting down on every cycle with en=1
// ST_PAUSE | counting suspended; value held until start
module bcd_countdown60 #(
  parameter int AUTO_RELOAD = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] ld_mm,
  input  logic [7:0] ld_ss,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       busy,
  output logic       done,
  output logic       bout,
  output logic       ld_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] mm_q, mm_d;
  logic [7:0] ss_q, ss_d;
  logic [7:0] rld_mm_q, rld_mm_d;
  logic [7:0] rld_ss_q, rld_ss_d;
  logic       done_q, done_d;
  logic       ld_err_q, ld_err_d;

  logic [7:0] ld_mm_sat;
  logic [7:0] ld_ss_sat;
  logic [7:0] mm_dec;
  logic [7:0] ss_dec;
  logic       ss_zero;
  logic       val_zero;
  logic       val_one;

  function automatic logic [7:0] sat_bcd60(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = (v[7:4] > 4'd5) ? 4'd5 : v[7:4];
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {t, u};
  endfunction

  function automatic logic [7:0] dec_bcd60(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] u;
    t = v[7:4];
    if (v[3:0] == 4'd0) begin
      u = 4'd9;
      t = (v[7:4] == 4'd0) ? 4'd5 : v[7:4] - 4'd1;
    end else begin
      u = v[3:0] - 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic sat_hit(input logic [7:0] v);
    return (v[7:4] > 4'd5) || (v[3:0] > 4'd9);
  endfunction

  assign ld_mm_sat = sat_bcd60(ld_mm);
  assign ld_ss_sat = sat_bcd60(ld_ss);
  assign mm_dec    = dec_bcd60(mm_q);
  assign ss_dec    = dec_bcd60(ss_q);
  assign ss_zero   = (ss_q == 8'h00);
  assign val_zero  = (mm_q == 8'h00) && ss_zero;
  assign val_one   = (mm_q == 8'h00) && (ss_q == 8'h01);

  always_comb begin
    state_d  = state_q;
    mm_d     = mm_q;
    ss_d     = ss_q;
    rld_mm_d = rld_mm_q;
    rld_ss_d = rld_ss_q;
    ld_err_d = ld_err_q;
    done_d   = 1'b0;

    if (load) begin
      state_d  = ST_IDLE;
      mm_d     = ld_mm_sat;
      ss_d     = ld_ss_sat;
      rld_mm_d = ld_mm_sat;
      rld_ss_d = ld_ss_sat;
      ld_err_d = sat_hit(ld_mm) || sat_hit(ld_ss);
    end else if (stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end
    end else if (start && (state_q != ST_RUN)) begin
      if ((state_q == ST_PAUSE) || !val_zero) begin
        state_d = ST_RUN;
      end
    end else if ((state_q == ST_RUN) && en) begin
      if (val_one) begin
        // A reload of 00:01 expires every tick; masking keeps done from running back-to-back.
        done_d = ~done_q;
        if (AUTO_RELOAD != 0) begin
          mm_d = rld_mm_q;
          ss_d = rld_ss_q;
        end else begin
          mm_d    = 8'h00;
          ss_d    = 8'h00;
          state_d = ST_IDLE;
        end
      end else begin
        ss_d = ss_dec;
        if (ss_zero) begin
          mm_d = mm_dec;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      mm_q     <= 8'h00;
      ss_q     <= 8'h00;
      rld_mm_q <= 8'h00;
      rld_ss_q <= 8'h00;
      done_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mm_q     <= mm_d;
      ss_q     <= ss_d;
      rld_mm_q <= rld_mm_d;
      rld_ss_q <= rld_ss_d;
      done_q   <= done_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign mm     = mm_q;
  assign ss     = ss_q;
  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
  assign ld_err = ld_err_q;
  assign bout   = busy & en & ss_zero;

endmodule

// File: tb/tb_bcd_countdown60.sv
// Directed bench for bcd_countdown60: one stopping instance and one auto-reload instance
// share the stimulus; each step is checked against hand-computed values.
module tb_bcd_countdown60;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       load;
  logic [7:0] ld_mm;
  logic [7:0] ld_ss;
  logic       start;
  logic       stop;

  logic [7:0] mm0, ss0, mm1, ss1;
  logic       busy0, done0, bout0, ld_err0;
  logic       busy1, done1, bout1, ld_err1;

  int checks   = 0;
  int failures = 0;
  int sec;

  bcd_countdown60 #(.AUTO_RELOAD(0)) u_dut (
    .clk(clk), .rstn(rstn), .en(en), .load(load), .ld_mm(ld_mm), .ld_ss(ld_ss),
    .start(start), .stop(stop), .mm(mm0), .ss(ss0), .busy(busy0), .done(done0),
    .bout(bout0), .ld_err(ld_err0)
  );

  bcd_countdown60 #(.AUTO_RELOAD(1)) u_ar (
    .clk(clk), .rstn(rstn), .en(en), .load(load), .ld_mm(ld_mm), .ld_ss(ld_ss),
    .start(start), .stop(stop), .mm(mm1), .ss(ss1), .busy(busy1), .done(done1),
    .bout(bout1), .ld_err(ld_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load  = 1'b1;
    ld_mm = m;
    ld_ss = s;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    ld_mm = 8'h00; ld_ss = 8'h00;
    #12;
    chk("rst_mm", mm0, 8'h00);
    chk("rst_ss", ss0, 8'h00);
    chk("rst_busy", {7'd0, busy0}, 8'd0);
    chk("rst_done", {7'd0, done0}, 8'd0);
    chk("rst_ld_err", {7'd0, ld_err0}, 8'd0);
    rstn = 1'b1;

    // 01:05 runs to expiry without reload
    do_load(8'h01, 8'h05);
    chk("t1_load_mm", mm0, 8'h01);
    chk("t1_load_ss", ss0, 8'h05);
    chk("t1_load_busy", {7'd0, busy0}, 8'd0);
    do_start();
    chk("t1_start_busy", {7'd0, busy0}, 8'd1);
    chk("t1_start_ss", ss0, 8'h05);
    en  = 1'b1;
    sec = 65;
    for (int i = 0; i < 65; i++) begin
      chk($sformatf("t1_bout_%0d", i), {7'd0, bout0}, {7'd0, (sec == 60)});
      step();
      sec--;
      chk($sformatf("t1_val_%0d", i), {mm0, ss0} == to_bcd(sec) ? 8'd1 : 8'd0, 8'd1);
      chk($sformatf("t1_done_%0d", i), {7'd0, done0}, {7'd0, (sec == 0)});
    end
    chk("t1_end_mm", mm0, 8'h00);
    chk("t1_end_ss", ss0, 8'h00);
    chk("t1_end_busy", {7'd0, busy0}, 8'd0);
    chk("t1_end_bout", {7'd0, bout0}, 8'd0);
    step();
    chk("t1_done_once", {7'd0, done0}, 8'd0);
    chk("t1_idle_hold", ss0, 8'h00);
    en = 1'b0;

    // Saturating loads
    do_load(8'h6C, 8'h7A);
    chk("t2_sat_mm", mm0, 8'h59);
    chk("t2_sat_ss", ss0, 8'h59);
    chk("t2_sat_err", {7'd0, ld_err0}, 8'd1);
    do_load(8'h0B, 8'h4F);
    chk("t2_units_mm", mm0, 8'h09);
    chk("t2_units_ss", ss0, 8'h49);
    chk("t2_units_err", {7'd0, ld_err0}, 8'd1);
    do_load(8'h00, 8'h10);
    chk("t2_ok_ss", ss0, 8'h10);
    chk("t2_ok_err", {7'd0, ld_err0}, 8'd0);

    // Pause and resume
    do_load(8'h00, 8'h20);
    do_start();
    en = 1'b1;
    repeat (5) step();
    chk("t3_run5_ss", ss0, 8'h15);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t3_pause_busy", {7'd0, busy0}, 8'd0);
    repeat (10) step();
    chk("t3_pause_mm", mm0, 8'h00);
    chk("t3_pause_ss", ss0, 8'h15);
    chk("t3_pause_bout", {7'd0, bout0}, 8'd0);
    do_start();
    chk("t3_resume_busy", {7'd0, busy0}, 8'd1);
    chk("t3_resume_ss", ss0, 8'h15);
    step();
    chk("t3_first_tick", ss0, 8'h14);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    chk("t3_stop_wins_busy", {7'd0, busy0}, 8'd0);
    chk("t3_stop_wins_ss", ss0, 8'h14);
    en = 1'b0;

    // Auto-reload period of 3 ticks
    do_load(8'h00, 8'h03);
    do_start();
    en = 1'b1;
    step(); chk("t4_ss_a", ss1, 8'h02); chk("t4_done_a", {7'd0, done1}, 8'd0);
    step(); chk("t4_ss_b", ss1, 8'h01); chk("t4_done_b", {7'd0, done1}, 8'd0);
    step(); chk("t4_ss_c", ss1, 8'h03); chk("t4_done_c", {7'd0, done1}, 8'd1);
    chk("t4_busy_c", {7'd0, busy1}, 8'd1);
    chk("t4_noreload_ss", ss0, 8'h00);
    chk("t4_noreload_busy", {7'd0, busy0}, 8'd0);
    step(); chk("t4_ss_d", ss1, 8'h02); chk("t4_done_d", {7'd0, done1}, 8'd0);
    step(); chk("t4_ss_e", ss1, 8'h01); chk("t4_done_e", {7'd0, done1}, 8'd0);
    step(); chk("t4_ss_f", ss1, 8'h03); chk("t4_done_f", {7'd0, done1}, 8'd1);
    chk("t4_busy_f", {7'd0, busy1}, 8'd1);
    en = 1'b0;

    // Reload of 00:01 expires every tick but done alternates
    do_load(8'h00, 8'h01);
    do_start();
    en = 1'b1;
    step(); chk("t4b_done_1", {7'd0, done1}, 8'd1); chk("t4b_ss_1", ss1, 8'h01);
    step(); chk("t4b_done_2", {7'd0, done1}, 8'd0);
    step(); chk("t4b_done_3", {7'd0, done1}, 8'd1);
    chk("t4b_busy", {7'd0, busy1}, 8'd1);
    en = 1'b0;

    // Asynchronous reset mid-run, then a refused start from 00:00
    do_load(8'h00, 8'h3A);
    chk("t5_err_set", {7'd0, ld_err0}, 8'd1);
    do_start();
    en = 1'b1;
    repeat (3) step();
    chk("t5_run_ss", ss0, 8'h36);
    #2 rstn = 1'b0;
    #1;
    chk("t5_arst_ss", ss0, 8'h00);
    chk("t5_arst_busy", {7'd0, busy0}, 8'd0);
    chk("t5_arst_err", {7'd0, ld_err0}, 8'd0);
    chk("t5_arst_ar_busy", {7'd0, busy1}, 8'd0);
    #2 rstn = 1'b1;
    do_start();
    chk("t5_refused_busy", {7'd0, busy0}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t5_nodone_%0d", i), {7'd0, done0 | done1}, 8'd0);
    end
    chk("t5_zero_ss", ss0, 8'h00);
    en = 1'b0;

    // load and start together: load wins, no decrement
    en = 1'b1; load = 1'b1; start = 1'b1; ld_mm = 8'h00; ld_ss = 8'h07;
    step();
    load = 1'b0;
    chk("t6_ls_ss", ss0, 8'h07);
    chk("t6_ls_busy", {7'd0, busy0}, 8'd0);
    step();
    start = 1'b0;
    chk("t6_start_busy", {7'd0, busy0}, 8'd1);
    chk("t6_start_ss", ss0, 8'h07);
    step();
    chk("t6_tick_ss", ss0, 8'h06);
    en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
